// File: rtl/saw_pkg.sv
// Shared definitions for the stop-and-wait link: receiver states, CRC polynomial
// and default frame geometry, reused by both ends of the link.
package saw_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CHECK   = 2'd1,
      S_DELIVER = 2'd2,
      S_ACK     = 2'd3
   } saw_state_e;

   // x^4 + x + 1 with the implicit x^4 term dropped
   localparam logic [3:0] CRC_POLY = 4'b0011;

   localparam int SAW_BW = 10;
   localparam int SAW_DW = 5;
   localparam int SAW_CW = SAW_BW - 1 - SAW_DW;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/crc_serial_chk.sv
// Bit-serial polynomial divider, MSB first; a zero remainder after the whole
// frame (payload plus appended CRC) has been shifted in means the frame is intact.
module crc_serial_chk
   import saw_pkg::*;
#(
   parameter int             CW   = SAW_CW,
   parameter logic [CW-1:0]  POLY = CRC_POLY
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          i_clr,
   input  logic          i_shift,
   input  logic          i_bit,
   output logic [CW-1:0] o_rem
);

   logic [CW-1:0] r_rem;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         r_rem <= '0;
      else if (i_clr)
         r_rem <= '0;
      else if (i_shift)
         r_rem <= {r_rem[CW-2:0], i_bit} ^ (r_rem[CW-1] ? POLY : '0);
   end

   assign o_rem = r_rem;

endmodule

// File: rtl/saw_receiver.sv
// Stop-and-wait receiver: accepts one frame, checks its CRC serially, delivers
// new payloads, acknowledges good frames and counts CRC errors and duplicates.
module saw_receiver
   import saw_pkg::*;
#(
   parameter int BW = SAW_BW,
   parameter int DW = SAW_DW
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic [BW-1:0] frame_in,
   input  logic          frame_valid,
   output logic          frame_ready,
   output logic [DW-1:0] data_out,
   output logic          data_valid,
   input  logic          data_ready,
   output logic          ack_seq,
   output logic          ack_valid,
   input  logic          ack_ready,
   output logic [7:0]    err_cnt,
   output logic [7:0]    dup_cnt
);

   localparam int CW   = BW - 1 - DW;
   localparam int CNTW = $clog2(BW);

   saw_state_e    r_state, w_state_nxt;
   logic          r_seq;
   logic [DW-1:0] r_data;
   logic [BW-1:0] r_shreg;
   logic [CNTW-1:0] r_bit_cnt;
   logic          r_chk_done;
   logic          r_exp_seq;
   logic [7:0]    r_err_cnt, r_dup_cnt;
   logic [CW-1:0] w_rem;
   logic          w_accept, w_shift, w_err, w_dup, w_deliver;

   crc_serial_chk #(.CW(CW)) u_crc (
      .clk     (clk),
      .rstn    (rstn),
      .i_clr   (w_accept),
      .i_shift (w_shift),
      .i_bit   (r_shreg[BW-1]),
      .o_rem   (w_rem)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // The verdict is taken one cycle after the last shift so it sees the
   // registered remainder including the final bit.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_shift     = 1'b0;
      w_err       = 1'b0;
      w_dup       = 1'b0;
      w_deliver   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (frame_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = S_CHECK;
            end
         end
         S_CHECK: begin
            if (!r_chk_done) begin
               w_shift = 1'b1;
            end else if (w_rem != '0) begin
               w_err       = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (r_seq == r_exp_seq) begin
               w_state_nxt = S_DELIVER;
            end else begin
               w_dup       = 1'b1;
               w_state_nxt = S_ACK;
            end
         end
         S_DELIVER: begin
            if (data_ready) begin
               w_deliver   = 1'b1;
               w_state_nxt = S_ACK;
            end
         end
         S_ACK: begin
            if (ack_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_seq      <= 1'b0;
         r_data     <= '0;
         r_shreg    <= '0;
         r_bit_cnt  <= '0;
         r_chk_done <= 1'b0;
         r_exp_seq  <= 1'b0;
         r_err_cnt  <= '0;
         r_dup_cnt  <= '0;
      end else begin
         if (w_accept) begin
            r_seq      <= frame_in[BW-1];
            r_data     <= frame_in[BW-2 -: DW];
            r_shreg    <= frame_in;
            r_bit_cnt  <= '0;
            r_chk_done <= 1'b0;
         end
         if (w_shift) begin
            r_shreg <= {r_shreg[BW-2:0], 1'b0};
            if (r_bit_cnt == CNTW'(BW-1)) begin
               r_bit_cnt  <= '0;
               r_chk_done <= 1'b1;
            end else begin
               r_bit_cnt <= r_bit_cnt + CNTW'(1);
            end
         end
         if (w_err)     r_err_cnt <= sat_inc(r_err_cnt);
         if (w_dup)     r_dup_cnt <= sat_inc(r_dup_cnt);
         if (w_deliver) r_exp_seq <= ~r_exp_seq;
      end
   end

   assign frame_ready = (r_state == S_IDLE);
   assign data_valid  = (r_state == S_DELIVER);
   assign ack_valid   = (r_state == S_ACK);
   assign data_out    = data_valid ? r_data : '0;
   assign ack_seq     = ack_valid ? r_seq : 1'b0;
   assign err_cnt     = r_err_cnt;
   assign dup_cnt     = r_dup_cnt;

endmodule
